uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz (the CPU's halved clock).
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port uart_rx  input  1  serial line; idles high; asynchronous to clk.
REQ-006 Port rx_data  output  8  last accepted byte.
REQ-007 Port rx_valid  output  1  high while rx_data holds an unconsumed byte.
REQ-008 Port rx_ack  input  1  consumer strobe; clears rx_valid.
REQ-009 Port rx_ferr  output  1  one-cycle pulse on a framing error (stop bit sampled 0).
REQ-010 Port rx_overrun  output  1  one-cycle pulse when a good byte is dropped because rx_valid is still high.

Function
REQ-011 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-012 uart_rx SHALL pass through a 2-flop synchronizer before any use; all timing figures below count from the synchronized signal.
REQ-013 Oversampling SHALL be 16x: tick divisor DIV = floor(CLK_HZ/(BAUD*16)); the tick counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1, then wraps to 0.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE: on synchronized line = 0, clear the tick phase counter, go to START.
REQ-016 START: after 8 ticks (mid start bit), if line = 0 go to DATA; if line = 1, treat as a glitch and return to IDLE with no output activity.
REQ-017 DATA: sample line every 16 ticks (mid-bit); shift into bit index 0..7; after bit 7 go to STOP.
REQ-018 STOP: sample after 16 ticks; if 1, deliver the byte (REQ-019/020) and go to IDLE; if 0, pulse rx_ferr, discard the byte, go to BREAK.
REQ-019 Delivery with rx_valid = 0, or rx_valid = 1 and rx_ack = 1 in the same cycle: rx_data SHALL update and rx_valid SHALL be 1 from the next clock; no overrun.
REQ-020 Delivery with rx_valid = 1 and rx_ack = 0: rx_data SHALL be unchanged, rx_valid SHALL stay 1, rx_overrun SHALL pulse for one cycle.
REQ-021 BREAK: remain until the synchronized line = 1, then go to IDLE.
REQ-022 rx_ack with no delivery in that cycle SHALL clear rx_valid on the next clock; rx_ack while rx_valid = 0 SHALL have no effect.
REQ-023 rx_data, rx_valid, rx_ferr and rx_overrun SHALL all be registered outputs.
REQ-024 Delivery latency: rx_valid SHALL rise one clock after the stop-bit sample tick.

Reset
REQ-025 While reset = 1: FSM = IDLE; tick, phase and bit counters = 0; shift register = 0; rx_data = 8'h00; rx_valid = rx_ferr = rx_overrun = 0; synchronizer flops = 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, reception resumes at the next falling edge.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state type, OVERSAMPLE = 16, DATA_BITS = 8 and the DIV computation function; the planned uart_transmitter SHALL reuse it.
REQ-028 The baud tick generator SHALL be a separate sub-module, uart_baud_tick (ports: clk, reset, clr, tick; parameter DIV).

Verification (CLK_HZ = 1600000, BAUD = 10000, so DIV = 10 and a bit is 160 cycles)
REQ-029 Good frame 0xA5, rx_ack held 0 -> rx_data = 0xA5 and rx_valid = 1 exactly one clock after the stop sample tick; rx_ferr = rx_overrun = 0.
REQ-030 40-cycle low glitch on an idle line -> FSM returns to IDLE; rx_valid, rx_ferr and rx_overrun stay 0.
REQ-031 Frame 0x3C with stop bit 0, line then held low 500 cycles then high, then good frame 0x81 -> one rx_ferr pulse, no valid for 0x3C; rx_data = 0x81 with rx_valid = 1.
REQ-032 Good frames 0x11 then 0x22, no ack -> rx_data stays 0x11, rx_valid stays 1, exactly one rx_overrun pulse.
REQ-033 rx_ack asserted in the same cycle 0x22 is delivered (0x11 pending) -> rx_data = 0x22, rx_valid stays 1, no overrun.
REQ-034 reset pulsed during data bit 4 of a frame -> all outputs reset values; next frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, frame geometry and baud divisor math.
// The receiver and the planned transmitter both import this package.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Clock cycles per oversample tick, rounded down.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and flags the last count.
// Holding clr keeps the phase at zero so a frame starts on a fresh tick period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, framing-error
// detection with break wait, and a single-entry holding register with overrun.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_ferr,
    output logic       rx_overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int PW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [PW-1:0] HALF_LAST  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

    logic                 sync1_q, sync2_q;
    uart_state_e          state_q;
    logic [PW-1:0]        phase_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q, rx_ferr_q, rx_overrun_q;
    logic                 tick, tick_clr;

    assign tick_clr = (state_q == ST_IDLE);

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_ferr_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
            if (rx_ack && rx_valid_q) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!sync2_q) begin
                        phase_q <= '0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (phase_q == HALF_LAST) begin
                            phase_q <= '0;
                            bit_q   <= '0;
                            state_q <= sync2_q ? ST_IDLE : ST_DATA;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        phase_q <= phase_q + 1'b1;
                        if (phase_q == PHASE_LAST) begin
                            shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                            if (bit_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        phase_q <= phase_q + 1'b1;
                        if (phase_q == PHASE_LAST) begin
                            if (sync2_q) begin
                                // An ack in the delivery cycle frees the slot for the new byte.
                                if (!rx_valid_q || rx_ack) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    rx_overrun_q <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                            end else begin
                                rx_ferr_q <= 1'b1;
                                state_q   <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (sync2_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_ferr    = rx_ferr_q;
    assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frame table, hand-written corner sequences,
// and random frames scored against a frame-level behavioural model.
module tb_uart_receiver;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 10000;
    localparam int DIV    = CLK_HZ / (BAUD * 16);
    localparam int BITC   = DIV * 16;
    // Line falls after edge 0; synchronized low after edge 2; START entered at edge 3;
    // stop sample tick is tick number 8 + 9*16 after that, so delivery lands on this edge.
    localparam int STOP_EDGE = 3 + DIV * (8 + 16 * 9);

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_overrun;

    int checks = 0;
    int passed = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int f0, o0;

    uart_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_ferr    (rx_ferr),
        .rx_overrun (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_ferr)    ferr_cnt <= ferr_cnt + 1;
        if (rx_overrun) ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_data"},  rx_data, 0);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_ferr"},  rx_ferr, 0);
        check({tag, "_ovr"},   rx_overrun, 0);
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Drives one frame cycle by cycle. abort_c >= 0 pulses reset at that cycle and idles the line.
    task automatic send_frame(input logic [7:0] b, input bit stopb, input int extra_low,
                              input bit ack_at, input bit chk_lat, input int abort_c);
        logic [9:0] fr;
        int total;
        fr = {stopb, b, 1'b0};
        total = 10 * BITC + extra_low + 40;
        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #1;
            if (abort_c >= 0 && c >= abort_c) begin
                uart_rx = 1'b1;
                reset = (c < abort_c + 3);
                if (c == abort_c + 1) check_reset_vals("midframe_reset");
            end else if (c < 10 * BITC) begin
                uart_rx = fr[c / BITC];
            end else begin
                uart_rx = (c < 10 * BITC + extra_low) ? 1'b0 : 1'b1;
            end
            rx_ack = ack_at && (c == STOP_EDGE - 1);
            if (chk_lat && c == STOP_EDGE - 1) check("latency_valid_early", rx_valid, 0);
            if (chk_lat && c == STOP_EDGE) begin
                check("latency_valid_on_time", rx_valid, 1);
                check("latency_data", rx_data, b);
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stopb;
        int         extra_low;
        bit         pre_ack;
        bit         ack_at;
        bit         chk_lat;
        logic [7:0] exp_data;
        bit         exp_valid;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] m_data;
        bit         m_valid;
        logic [7:0] rb;
        bit         rstop, rpre, rack;
        int         rlow, exp_f, exp_o;

        vecs[0] = '{8'hA5, 1'b1,   0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1, 0};
        vecs[0].exp_ferr = 0;
        vecs[1] = '{8'h3C, 1'b0, 500, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1, 0};
        vecs[2] = '{8'h81, 1'b1,   0, 1'b1, 1'b0, 1'b0, 8'h81, 1'b1, 0, 0};
        vecs[3] = '{8'h11, 1'b1,   0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 0, 0};
        vecs[4] = '{8'h22, 1'b1,   0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 0, 1};
        vecs[5] = '{8'h22, 1'b1,   0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 0, 0};

        reset = 1'b1;
        uart_rx = 1'b1;
        rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        reset = 1'b0;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[i].pre_ack) pulse_ack();
            send_frame(vecs[i].data, vecs[i].stopb, vecs[i].extra_low, vecs[i].ack_at, vecs[i].chk_lat, -1);
            check($sformatf("vec%0d_data", i),  rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i),  ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i),   ovr_cnt - o0, vecs[i].exp_ovr);
        end

        // Short low glitch on an idle line must be rejected silently.
        pulse_ack();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        @(posedge clk); #1 uart_rx = 1'b0;
        repeat (40) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);
        send_frame(8'h96, 1'b1, 0, 1'b0, 1'b0, -1);
        check("after_glitch_data", rx_data, 8'h96);
        check("after_glitch_valid", rx_valid, 1);

        // Random frames against a frame-level model of the holding register.
        m_data = 8'h96;
        m_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            rpre  = 1'($urandom_range(0, 1));
            rack  = 1'($urandom_range(0, 1));
            rlow  = rstop ? 0 : int'($urandom_range(0, 100));
            exp_f = 0;
            exp_o = 0;
            if (rpre) m_valid = 1'b0;
            if (!rstop) begin
                exp_f = 1;
                if (rack) m_valid = 1'b0;
            end else if (!m_valid || rack) begin
                m_data = rb;
                m_valid = 1'b1;
            end else begin
                exp_o = 1;
            end
            repeat ($urandom_range(5, 60)) @(posedge clk);
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (rpre) pulse_ack();
            send_frame(rb, rstop, rlow, rack, 1'b0, -1);
            check($sformatf("rnd%0d_data", i),  rx_data, m_data);
            check($sformatf("rnd%0d_valid", i), rx_valid, m_valid);
            check($sformatf("rnd%0d_ferr", i),  ferr_cnt - f0, exp_f);
            check($sformatf("rnd%0d_ovr", i),   ovr_cnt - o0, exp_o);
        end

        // Reset during data bit 4 with a byte pending, then a clean frame.
        pulse_ack();
        send_frame(8'h77, 1'b1, 0, 1'b0, 1'b0, -1);
        check("prereset_data", rx_data, 8'h77);
        check("prereset_valid", rx_valid, 1);
        send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0, 5 * BITC + 80);
        #1 check_reset_vals("after_abort");
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        send_frame(8'h5A, 1'b1, 0, 1'b0, 1'b0, -1);
        check("postreset_data", rx_data, 8'h5A);
        check("postreset_valid", rx_valid, 1);
        check("postreset_ferr", ferr_cnt - f0, 0);
        check("postreset_ovr", ovr_cnt - o0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
